// File: rtl/prog_mem_sync.sv
// rtl/prog_mem_sync.sv - clocked program memory with address register, loader write port and range checking
module prog_mem_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              set_addr,
    input  logic              inc_addr,
    input  logic              en_data,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic [ADDR_W:0]   noi,
    output logic              addr_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] ar;
    logic [ADDR_W:0]   ar_inc;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Next sequential address in ADDR_W+1 bits so DEPTH = 2^ADDR_W compares correctly
    always_comb begin
        ar_inc   = {1'b0, ar} + (ADDR_W + 1)'(1);
        in_range = ({1'b0, ar} < DEPTH_W);
        idx      = ar[IDX_W-1:0];
    end

    // Address register: load wins over increment; increment wraps at DEPTH (or from any out-of-range value)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ar <= '0;
        end else if (set_addr) begin
            ar <= addr;
        end else if (inc_addr) begin
            ar <= (ar_inc >= DEPTH_W) ? '0 : ar_inc[ADDR_W-1:0];
        end
    end

    // Accesses use the pre-update AR; write-first on a same-cycle read; array itself is never cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            noi        <= '0;
            addr_err   <= 1'b0;
        end else begin
            data_valid <= en_data;
            if (en_data) begin
                if (!in_range) begin
                    data <= '0;
                end else if (wr_en) begin
                    data <= wr_data;
                end else begin
                    data <= mem[idx];
                end
            end
            if (wr_en && in_range) begin
                mem[idx] <= wr_data;
                if (ar_inc > noi) begin
                    noi <= ar_inc;
                end
            end
            if ((en_data || wr_en) && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_sync.sv
// tb/tb_prog_mem_sync.sv - scoreboard testbench for prog_mem_sync
module tb_prog_mem_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] addr, wr_data, data;
    logic       set_addr, inc_addr, en_data, wr_en, data_valid, addr_err;
    logic [8:0] noi;

    logic [7:0] b_addr, b_wr_data, b_data;
    logic       b_set_addr, b_inc_addr, b_en_data, b_wr_en, b_data_valid, b_addr_err;
    logic [8:0] b_noi;

    prog_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_full (
        .clk(clk), .reset_n(reset_n), .addr(addr), .set_addr(set_addr),
        .inc_addr(inc_addr), .en_data(en_data), .wr_en(wr_en), .wr_data(wr_data),
        .data(data), .data_valid(data_valid), .noi(noi), .addr_err(addr_err)
    );

    prog_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) u_small (
        .clk(clk), .reset_n(reset_n), .addr(b_addr), .set_addr(b_set_addr),
        .inc_addr(b_inc_addr), .en_data(b_en_data), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .data(b_data), .data_valid(b_data_valid), .noi(b_noi), .addr_err(b_addr_err)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mem_m [256];
    int         ar_m;
    int         noi_m;
    logic [7:0] sb_q [$];
    logic [7:0] prog [16];
    int         run_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle0();
        addr = '0; wr_data = '0; set_addr = 0; inc_addr = 0; en_data = 0; wr_en = 0;
    endtask

    task automatic idle1();
        b_addr = '0; b_wr_data = '0; b_set_addr = 0; b_inc_addr = 0; b_en_data = 0; b_wr_en = 0;
    endtask

    // One clock of the full-depth instance: model the inputs, push expected read data, then compare
    task automatic step0();
        logic exp_valid;
        exp_valid = en_data;
        if (en_data) sb_q.push_back(wr_en ? wr_data : mem_m[ar_m]);
        if (wr_en) begin
            mem_m[ar_m] = wr_data;
            if (ar_m + 1 > noi_m) noi_m = ar_m + 1;
        end
        if (set_addr) ar_m = int'(addr);
        else if (inc_addr) ar_m = (ar_m + 1) % 256;
        @(posedge clk);
        #1;
        check("valid", 32'(data_valid), 32'(exp_valid));
        if (data_valid) begin
            if (sb_q.size() == 0) check("sb_underrun", 32'd1, 32'd0);
            else check("data", 32'(data), 32'(sb_q.pop_front()));
        end
        check("noi", 32'(noi), 32'(noi_m));
        check("err", 32'(addr_err), 32'd0);
    endtask

    initial begin
        prog = '{8'h20, 8'h00, 8'h21, 8'h05, 8'h22, 8'h0A, 8'h23, 8'h0F,
                 8'h24, 8'h14, 8'h25, 8'h19, 8'h26, 8'h1E, 8'hFF, 8'h00};
        ar_m = 0; noi_m = 0;
        idle0(); idle1();
        reset_n = 0;
        #12;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_noi", 32'(noi), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_b_noi", 32'(b_noi), 32'd0);
        @(negedge clk);
        reset_n = 1;

        // load program
        set_addr = 1; addr = 8'd0; step0();
        set_addr = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; inc_addr = 1; wr_data = prog[i]; step0();
        end
        idle0();
        check("t1_noi", 32'(noi), 32'd16);
        wr_en = 1; wr_data = 8'h77; step0();
        idle0();
        check("t1_ar16", 32'(noi), 32'd17);

        // burst read
        set_addr = 1; addr = 8'd0; step0();
        set_addr = 0;
        run_len = 0;
        for (int i = 0; i < 16; i++) begin
            en_data = 1; inc_addr = 1; step0();
            if (data_valid) run_len++;
        end
        idle0(); step0();
        check("t2_run", 32'(run_len), 32'd16);
        check("t2_hold", 32'(data), 32'h00);

        // wrap and priority
        set_addr = 1; addr = 8'd255; step0();
        set_addr = 0; inc_addr = 1; step0();
        inc_addr = 0; en_data = 1; step0();
        check("t3_wrap", 32'(data), 32'h20);
        en_data = 1; set_addr = 1; addr = 8'd7; inc_addr = 1; step0();
        set_addr = 0; inc_addr = 0; step0();
        check("t3_prio", 32'(data), 32'h0F);
        idle0();

        // write-first collision
        set_addr = 1; addr = 8'd3; step0();
        set_addr = 0; wr_en = 1; wr_data = 8'hAA; step0();
        wr_data = 8'h55; en_data = 1; step0();
        check("t4_wf", 32'(data), 32'h55);
        wr_en = 0; step0();
        check("t4_reread", 32'(data), 32'h55);
        idle0(); step0();

        // out-of-range on the 16-word instance
        b_wr_en = 1; b_wr_data = 8'h11; b_set_addr = 1; b_addr = 8'd20; step0();
        check("t5_noi1", 32'(b_noi), 32'd1);
        check("t5_err0", 32'(b_addr_err), 32'd0);
        idle1(); b_wr_en = 1; b_wr_data = 8'h99; step0();
        check("t5_err_wr", 32'(b_addr_err), 32'd1);
        check("t5_noi_hold", 32'(b_noi), 32'd1);
        idle1(); b_en_data = 1; step0();
        check("t5_rd_valid", 32'(b_data_valid), 32'd1);
        check("t5_rd_zero", 32'(b_data), 32'd0);
        b_inc_addr = 1; step0();
        check("t5_rd_zero2", 32'(b_data), 32'd0);
        b_inc_addr = 0; step0();
        check("t5_wrap_rd", 32'(b_data), 32'h11);
        idle1(); step0(); step0(); step0();
        check("t5_sticky", 32'(b_addr_err), 32'd1);
        check("t5_valid0", 32'(b_data_valid), 32'd0);

        // async reset mid-burst
        set_addr = 1; addr = 8'd0; step0();
        set_addr = 0; en_data = 1; inc_addr = 1;
        step0(); step0(); step0();
        #3;
        reset_n = 0;
        #1;
        check("t6_data", 32'(data), 32'd0);
        check("t6_valid", 32'(data_valid), 32'd0);
        check("t6_noi", 32'(noi), 32'd0);
        check("t6_b_err", 32'(b_addr_err), 32'd0);
        check("t6_b_noi", 32'(b_noi), 32'd0);
        sb_q.delete();
        ar_m = 0; noi_m = 0;
        idle0();
        @(negedge clk);
        reset_n = 1;
        en_data = 1; step0();
        check("t6_rd0", 32'(data), 32'h20);
        idle0(); step0();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
